// File: rtl/task_scheduler.sv
// Program feeder for the gpu_core array: streams a 16-word program into idle cores
// round-robin and counts completed core-runs until the requested job size is reached.
module task_scheduler #(
    parameter int NUM_CORES = 8,
    parameter int PROG_LEN  = 16,
    parameter int CNT_W     = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 host_wr_en_i,
    input  logic [3:0]           host_wr_addr_i,
    input  logic [15:0]          host_wr_data_i,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     task_count_i,
    input  logic [NUM_CORES-1:0] rtr_i,
    input  logic [NUM_CORES-1:0] ready_i,
    output logic [NUM_CORES-1:0] val_ins_o,
    output logic [15:0]          instruction_o,
    output logic [NUM_CORES-1:0] busy_cores_o,
    output logic [CNT_W-1:0]     tasks_done_o,
    output logic                 done_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_SEND   = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int IDX_W = $clog2(PROG_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [15:0]          prog_q [PROG_LEN];
    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     target_q, target_d;
    logic [CNT_W-1:0]     issued_q, issued_d;
    logic [CNT_W-1:0]     tasks_done_q, tasks_done_d;
    logic                 done_q, done_d;
    logic [NUM_CORES-1:0] busy_q, busy_d;
    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_CORES-1:0] val_q, val_d;
    logic [15:0]          instr_q, instr_d;
    logic [NUM_CORES-1:0] ready_prev_q;

    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] done_edge;
    logic                 grant_vld;
    logic [PTR_W-1:0]     grant_idx;
    logic [CNT_W+4:0]     done_sum;
    logic [CNT_W-1:0]     done_sat;

    assign eligible  = rtr_i & ~busy_q;
    // Only a rising ready on a core we actually dispatched counts as a completion.
    assign done_edge = ready_i & ~ready_prev_q & busy_q;

    always_comb begin
        int j;
        logic [PTR_W-1:0] jj;
        j         = 0;
        jj        = '0;
        grant_vld = 1'b0;
        grant_idx = rr_q;
        for (int i = 1; i <= NUM_CORES; i++) begin
            j = int'(rr_q) + i;
            if (j >= NUM_CORES) j = j - NUM_CORES;
            jj = PTR_W'(j);
            if (!grant_vld && eligible[jj]) begin
                grant_vld = 1'b1;
                grant_idx = jj;
            end
        end
    end

    always_comb begin
        done_sum = {5'b0, tasks_done_q};
        for (int k = 0; k < NUM_CORES; k++) begin
            done_sum = done_sum + (CNT_W+5)'(done_edge[k]);
        end
        done_sat = (done_sum > {5'b0, CNT_MAX}) ? CNT_MAX : done_sum[CNT_W-1:0];
    end

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        issued_d     = issued_q;
        tasks_done_d = tasks_done_q;
        done_d       = done_q;
        busy_d       = busy_q;
        rr_d         = rr_q;
        idx_d        = idx_q;
        val_d        = val_q;
        instr_d      = instr_q;

        if (state_q != S_IDLE) begin
            busy_d       = busy_q & ~done_edge;
            tasks_done_d = done_sat;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (task_count_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        target_d     = task_count_i;
                        issued_d     = '0;
                        tasks_done_d = '0;
                        done_d       = 1'b0;
                        state_d      = S_SELECT;
                    end
                end
            end
            S_SELECT: begin
                if (issued_q == target_q) begin
                    state_d = S_DRAIN;
                end else if (grant_vld) begin
                    // Word 0 goes out on the grant edge so the burst starts two cycles after start.
                    rr_d              = grant_idx;
                    busy_d[grant_idx] = 1'b1;
                    issued_d          = issued_q + 1'b1;
                    val_d             = '0;
                    val_d[grant_idx]  = 1'b1;
                    instr_d           = prog_q[0];
                    idx_d             = IDX_W'(1);
                    state_d           = S_SEND;
                end
            end
            S_SEND: begin
                if (idx_q == '0) begin
                    val_d   = '0;
                    instr_d = '0;
                    state_d = S_SELECT;
                end else begin
                    instr_d = prog_q[idx_q];
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: begin
                if (busy_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            target_q     <= '0;
            issued_q     <= '0;
            tasks_done_q <= '0;
            done_q       <= 1'b0;
            busy_q       <= '0;
            rr_q         <= PTR_W'(NUM_CORES - 1);
            idx_q        <= '0;
            val_q        <= '0;
            instr_q      <= '0;
            ready_prev_q <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            issued_q     <= issued_d;
            tasks_done_q <= tasks_done_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            rr_q         <= rr_d;
            idx_q        <= idx_d;
            val_q        <= val_d;
            instr_q      <= instr_d;
            ready_prev_q <= ready_i;
        end
    end

    // Program memory survives reset; the host reloads it only when it wants a new program.
    always_ff @(posedge clk_i) begin
        if (state_q == S_IDLE && host_wr_en_i) begin
            prog_q[host_wr_addr_i] <= host_wr_data_i;
        end
    end

    assign val_ins_o     = val_q;
    assign instruction_o = instr_q;
    assign busy_cores_o  = busy_q;
    assign tasks_done_o  = tasks_done_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_task_scheduler.sv
// Scoreboard bench for task_scheduler: stimulus queues expected bus words,
// a negedge monitor pops and compares every cycle the DUT drives val_ins.
module tb_task_scheduler;

    localparam int NC = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          host_wr_en;
    logic [3:0]    host_wr_addr;
    logic [15:0]   host_wr_data;
    logic          start;
    logic [7:0]    task_count;
    logic [NC-1:0] rtr;
    logic [NC-1:0] ready;
    logic [NC-1:0] val_ins;
    logic [15:0]   instruction;
    logic [NC-1:0] busy_cores;
    logic [7:0]    tasks_done;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [23:0] exp_q[$];
    logic [NC-1:0] hist [50];

    always #5 clk = ~clk;

    task_scheduler #(.NUM_CORES(NC), .PROG_LEN(16), .CNT_W(8)) dut (
        .clk_i(clk), .reset_ni(rst_n),
        .host_wr_en_i(host_wr_en), .host_wr_addr_i(host_wr_addr), .host_wr_data_i(host_wr_data),
        .start_i(start), .task_count_i(task_count), .rtr_i(rtr), .ready_i(ready),
        .val_ins_o(val_ins), .instruction_o(instruction), .busy_cores_o(busy_cores),
        .tasks_done_o(tasks_done), .done_o(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_burst(input int core, input int nwords);
        logic [NC-1:0] oh;
        oh = '0;
        oh[core] = 1'b1;
        for (int i = 0; i < nwords; i++) exp_q.push_back({oh, 16'h1000 + 16'(i)});
    endtask

    task automatic pulse_start(input int cnt);
        start = 1'b1;
        task_count = 8'(cnt);
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_ready(input logic [NC-1:0] mask);
        ready = mask;
        tick(1);
        ready = '0;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic wait_quiet(input int max, input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || val_ins != '0) && k < max) begin
            tick(1);
            k++;
        end
        n_tests++;
        if (k >= max) begin
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, %0d words still expected", name, k, exp_q.size());
        end
    endtask

    // Monitor: every driven bus cycle must match the next expected word.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && val_ins != '0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got val_ins=%h instr=%h expected none", val_ins, instruction);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_word", 32'({val_ins, instruction}), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [NC-1:0] ev;
        rst_n = 1'b0;
        host_wr_en = 1'b0;
        host_wr_addr = '0;
        host_wr_data = '0;
        start = 1'b0;
        task_count = '0;
        rtr = '0;
        ready = '0;
        tick(2);
        check("rst_val_ins", 32'(val_ins), 32'h0);
        check("rst_instr", 32'(instruction), 32'h0);
        check("rst_busy", 32'(busy_cores), 32'h0);
        check("rst_tasks_done", 32'(tasks_done), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        tick(1);

        for (int i = 0; i < 16; i++) begin
            host_wr_en = 1'b1;
            host_wr_addr = 4'(i);
            host_wr_data = 16'h1000 + 16'(i);
            tick(1);
        end
        host_wr_en = 1'b0;
        rtr = '1;

        // Single task on core 0, then its completion.
        push_burst(0, 16);
        pulse_start(1);
        check("t1_lat_pre", 32'(val_ins), 32'h0);
        tick(1);
        check("t1_lat_first", 32'(val_ins), 32'h01);
        check("t1_busy_send", 32'(busy_cores), 32'h01);
        wait_quiet(40, "t1_burst");
        check("t1_busy", 32'(busy_cores), 32'h01);
        check("t1_done_pre", 32'(done), 32'h0);
        pulse_ready(8'h01);
        check("t1_busy_clr", 32'(busy_cores), 32'h0);
        check("t1_tasks_done", 32'(tasks_done), 32'h1);
        tick(1);
        check("t1_done", 32'(done), 32'h1);

        // Three tasks: cores 0,1,2 back to back with one idle cycle between bursts.
        do_reset();
        push_burst(0, 16);
        push_burst(1, 16);
        push_burst(2, 16);
        pulse_start(3);
        tick(1);
        for (int c = 0; c < 50; c++) begin
            hist[c] = val_ins;
            tick(1);
        end
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            ev = '0;
            if ((c % 17) != 16) ev[c / 17] = 1'b1;
            if (hist[c] !== ev) bad++;
        end
        check("t2_burst_gaps", 32'(bad), 32'h0);
        wait_quiet(40, "t2_burst");
        check("t2_busy", 32'(busy_cores), 32'h07);
        pulse_ready(8'h20);
        check("t2_nonbusy_td", 32'(tasks_done), 32'h0);
        check("t2_nonbusy_busy", 32'(busy_cores), 32'h07);
        check("t2_done_pre", 32'(done), 32'h0);
        pulse_ready(8'h07);
        check("t2_multi_td", 32'(tasks_done), 32'h3);
        check("t2_busy_clr", 32'(busy_cores), 32'h0);
        tick(1);
        check("t2_done", 32'(done), 32'h1);

        // Ten tasks on eight cores: cores 3 then 0 finish and are reused.
        do_reset();
        for (int k = 0; k < 8; k++) push_burst(k, 16);
        pulse_start(10);
        wait_quiet(8 * 17 + 10, "t3_first8");
        check("t3_busy_all", 32'(busy_cores), 32'hFF);
        check("t3_done_pre", 32'(done), 32'h0);
        push_burst(3, 16);
        push_burst(0, 16);
        ready = 8'h08;
        tick(1);
        ready = 8'h01;
        tick(1);
        ready = '0;
        wait_quiet(60, "t3_reuse");
        check("t3_tasks_done_2", 32'(tasks_done), 32'h2);
        check("t3_busy_again", 32'(busy_cores), 32'hFF);
        check("t3_done_mid", 32'(done), 32'h0);
        pulse_ready(8'hFF);
        check("t3_tasks_done_10", 32'(tasks_done), 32'd10);
        tick(1);
        check("t3_done", 32'(done), 32'h1);

        // Reset at word 7 after a dropped host write; rerun proves the program is intact.
        push_burst(1, 8);
        pulse_start(1);
        tick(1);
        check("t4_core1", 32'(val_ins), 32'h02);
        tick(3);
        host_wr_en = 1'b1;
        host_wr_addr = 4'd5;
        host_wr_data = 16'hDEAD;
        tick(1);
        host_wr_en = 1'b0;
        tick(3);
        check("t4_word7", 32'(instruction), 32'h1007);
        #1 rst_n = 1'b0;
        #1;
        check("t4_rst_val", 32'(val_ins), 32'h0);
        check("t4_rst_instr", 32'(instruction), 32'h0);
        check("t4_rst_done", 32'(done), 32'h0);
        check("t4_rst_busy", 32'(busy_cores), 32'h0);
        check("t4_rst_queue", 32'(exp_q.size()), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        push_burst(0, 16);
        pulse_start(1);
        wait_quiet(40, "t4_rerun");
        pulse_ready(8'h01);
        tick(1);
        check("t4_done", 32'(done), 32'h1);
        check("final_queue", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
